// File: rtl/rv_pkg.sv
// Shared core definitions: datapath defaults, fetch state encoding and the
// base opcode constants used by the decoder.
package rv_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HOLD  = 2'b10
  } fetch_st_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_TGT  = 2'b10
  } pc_sel_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/if_pc_reg.sv
// Program counter with next-PC select: hold, sequential +4, or a redirect
// target forced to word alignment.
module if_pc_reg
  import rv_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         pc_sel_i,
  input  logic [XLEN-1:0] tgt_i,
  output logic [XLEN-1:0] pc_o
);
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel_i)
      PC_INC:  pc_d = pc_q + XLEN'(4);
      PC_TGT:  pc_d = tgt_i & ~XLEN'(3);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;

  assign pc_o = pc_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, captures the word
// and holds it for decode; redirects in flight mark the response for drop.
module if_fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic [6:0]      opcode
);
  fetch_st_e       state_q;
  logic            drop_q;
  logic            instr_valid_q;
  logic [XLEN-1:0] instr_q, instr_pc_q, instr_pc_plus4_q;
  logic [XLEN-1:0] pc;
  pc_sel_e         pc_sel;

  // Redirect always wins the PC, whatever the state.
  always_comb begin
    pc_sel = PC_HOLD;
    if (redirect_valid)                     pc_sel = PC_TGT;
    else if (state_q == ST_HOLD && !stall)  pc_sel = PC_INC;
  end

  if_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_sel_i (pc_sel),
    .tgt_i    (redirect_target),
    .pc_o     (pc)
  );

  assign imem_req_valid = rst_n && (state_q == ST_FETCH) && !redirect_valid;
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_FETCH;
      drop_q           <= 1'b0;
      instr_valid_q    <= 1'b0;
      instr_q          <= '0;
      instr_pc_q       <= '0;
      instr_pc_plus4_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: if (imem_req_valid && imem_req_ready) state_q <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            drop_q <= 1'b0;
            if (!drop_q && !redirect_valid) begin
              instr_q          <= imem_rsp_data;
              instr_pc_q       <= pc;
              instr_pc_plus4_q <= pc + XLEN'(4);
              instr_valid_q    <= 1'b1;
              state_q          <= ST_HOLD;
            end else begin
              state_q <= ST_FETCH;
            end
          end else if (redirect_valid) begin
            drop_q <= 1'b1;
          end
        end
        ST_HOLD: if (redirect_valid || !stall) begin
          instr_valid_q <= 1'b0;
          state_q       <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = instr_pc_plus4_q;
  assign opcode         = instr_q[6:0];
endmodule
